// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: start/stop/clear BCD stopwatch with prescaler, decade carry chain and lap hold
module bcd_stopwatch_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10,
    parameter bit WRAP     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  running,
    output logic                  lap_active,
    output logic                  overflow,
    output logic                  tick
);
    localparam int PW = $clog2(PRESCALE);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t                state_q, state_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic [4*DIGITS-1:0]   cnt_q, cnt_d, lap_q, lap_d, cnt_inc;
    logic                  lap_active_q, lap_active_d;
    logic                  overflow_q, overflow_d;
    logic                  lap_prev_q, lap_prev_d;
    logic                  all9;
    logic                  lap_edge;
    assign tick       = (state_q == RUN) && (pre_q == PW'(PRESCALE - 1));
    assign lap_edge   = lap && !lap_prev_q;
    assign running    = state_q == RUN;
    assign lap_active = lap_active_q;
    assign overflow   = overflow_q;
    assign bcd_out    = lap_active_q ? lap_q : cnt_q;
    // ripple-carry increment of the digit chain; all9 ends up as the carry out of the top digit
    always_comb begin
        cnt_inc = cnt_q;
        all9    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (all9) cnt_inc[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd9) ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
            all9 = all9 && (cnt_q[4*i +: 4] == 4'd9);
        end
    end
    // next state: clear overrides all, otherwise lap toggle, tick step, then stop over start
    always_comb begin
        state_d      = state_q;
        pre_d        = pre_q;
        cnt_d        = cnt_q;
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        overflow_d   = overflow_q;
        lap_prev_d   = lap;
        if (clear) begin
            state_d      = IDLE;
            pre_d        = '0;
            cnt_d        = '0;
            lap_active_d = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            if (lap_edge) begin
                lap_active_d = !lap_active_q;
                if (!lap_active_q) lap_d = cnt_q;
            end
            if (state_q == RUN) pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                cnt_d      = (all9 && !WRAP) ? cnt_q : cnt_inc;
                overflow_d = overflow_q || all9;
            end
            if (stop) state_d = (state_q == RUN) ? PAUSE : state_q;
            else if (start) state_d = RUN;
            if (tick && all9 && !WRAP) state_d = PAUSE;
        end
    end
    // registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pre_q        <= '0;
            cnt_q        <= '0;
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
            lap_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
            lap_prev_q   <= lap_prev_d;
        end
    end
endmodule
